addition_subtraction: RTL and testbench
=======================================

// Module: addition_subtraction
// PURPOSE
//  IEEE-754 single-precision (fp32) adder/subtractor with a registered output.
//  Used by the neuron potential-decay datapath, e.g. to form x/2 + x/4 for decay rate 4'b0011.
//  Also usable as a generic fp32 add/sub elsewhere in the SNN core.
//  Pure datapath block: no handshake, and a new operation can start every cycle.
// PARAMETERS
//  none. Format is fixed: sign[31], exponent[30:23] with bias 127, fraction[22:0].
// PORTS
//  clk          in   1   rising-edge clock (single clock domain)
//  reset        in   1   asynchronous, active-high reset
//  a_operand    in   32  fp32 operand A
//  b_operand    in   32  fp32 operand B
//  AddBar_Sub   in   1   0: Result = A + B; 1: Result = A - B (B sign inverted)
//  Exception    out  1   registered; 1 when the operation is exceptional (see BEHAVIOUR)
//  Result       out  32  registered fp32 result
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is asynchronous and active-high.
//  - While reset=1: Result=32'h0000_0000 and Exception=0 immediately, regardless of clk.
//  - Latency: 1 cycle. Inputs sampled at posedge N; Result/Exception valid after edge N and held to edge N+1.
//  - Throughput: one operation per cycle.
//  - Reset asserted mid-operation: the in-flight result is discarded.
//  - Operand classes:
//    - exponent == 0: operand is treated as zero (denormals flushed, fraction ignored).
//    - exponent == 8'hFF (Inf/NaN) in either operand: Exception=1 and Result=32'h7FC0_0000.
//  - Effective operation: B' = {b[31]^AddBar_Sub, b[30:0]}.
//    - If sign(A) == sign(B'): add magnitudes.
//    - Otherwise: subtract the smaller magnitude from the larger.
//    - Result sign is the sign of the larger-magnitude operand.
//  - Algorithm:
//    - Prepend the hidden 1 to each 24-bit significand.
//    - Swap operands so |X| >= |Y|, comparing {exp, frac}.
//    - Right-shift Y by (expX - expY). If the shift is >= 25, Y contributes 0.
//    - Add or subtract the significands in 25 bits.
//    - Addition carry-out: shift right 1 and exponent +1.
//    - Subtraction: leading-one detect, then shift left and reduce the exponent by the same amount.
//  - Rounding: truncation (round toward zero). Bits shifted out are discarded; no guard/sticky bits.
//  - Zero handling:
//    - Exact cancellation yields +0 (32'h0000_0000).
//    - If one operand is zero, the result equals the other operand, with its sign adjusted for subtraction.
//  - Overflow: if the result exponent reaches 255, Result = {sign, 8'hFF, 23'h0} and Exception=1.
//  - Underflow: if the normalized exponent is <= 0, Result = {sign, 31'h0} and Exception=0.
//  - Exception is 0 for all other cases.
// TESTING
//  - 32'h3F80_0000 + 32'h3F80_0000, AddBar_Sub=0 -> next cycle Result=32'h4000_0000, Exception=0.
//  - 32'h415E_D852 + 32'h40DE_D852 (13.93+6.96, decay x/2+x/4) -> Result=32'h41A7_223D (truncated).
//  - 32'h4040_0000 - 32'h3F80_0000 (3.0-1.0), AddBar_Sub=1 -> Result=32'h4000_0000.
//  - 32'h3F80_0000 - 32'h3F80_0000 -> Result=32'h0000_0000.
//  - 32'hC000_0000 + 32'h3F80_0000 -> Result=32'hBF80_0000.
//  - 32'h7F80_0000 + any -> Exception=1, Result=32'h7FC0_0000.
//  - 32'h7F7F_FFFF + 32'h7F7F_FFFF -> Exception=1, Result=32'h7F80_0000.
//  - Assert reset between edges while Result is nonzero -> outputs go to 0 at once without a clock edge.
//  - After release, the first posedge produces a valid result for the inputs applied at that edge.
//  - Back-to-back ops on consecutive cycles -> each result appears exactly one cycle after its inputs.

Source files
------------

// File: rtl/addition_subtraction.sv
// addition_subtraction: IEEE-754 single-precision adder/subtractor with a one-cycle registered
// output. Denormals are flushed to zero, rounding is truncation, and Inf/NaN inputs raise
// Exception with a canonical quiet NaN result.
module addition_subtraction (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] Result
);

  logic [31:0] b_eff;
  logic        a_zero, b_zero, any_special;
  logic [30:0] a_mag, b_mag;
  logic        swap;
  logic        x_sign;
  logic        eff_sub;
  logic [7:0]  x_exp, y_exp, exp_diff;
  logic [23:0] x_sig, y_sig, y_shift;
  logic [24:0] sum;
  logic [23:0] diff, diff_norm;
  logic [4:0]  lz;
  logic        lz_found;
  logic [8:0]  add_exp;
  logic signed [9:0] sub_exp;

  logic [31:0] result_d, result_q;
  logic        exception_d, exception_q;

  // Operand classification, magnitude ordering and alignment of the smaller operand.
  always_comb begin
    b_eff       = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
    a_zero      = (a_operand[30:23] == 8'h00);
    b_zero      = (b_eff[30:23] == 8'h00);
    any_special = (a_operand[30:23] == 8'hFF) || (b_eff[30:23] == 8'hFF);

    // Flushed operands compare as exact zero, whatever their fraction bits hold.
    a_mag = a_zero ? 31'h0 : a_operand[30:0];
    b_mag = b_zero ? 31'h0 : b_eff[30:0];
    swap  = (b_mag > a_mag);

    x_sign  = swap ? b_eff[31] : a_operand[31];
    eff_sub = a_operand[31] ^ b_eff[31];
    x_exp   = swap ? b_mag[30:23] : a_mag[30:23];
    y_exp   = swap ? a_mag[30:23] : b_mag[30:23];
    x_sig   = swap ? (b_zero ? 24'h0 : {1'b1, b_mag[22:0]})
                   : (a_zero ? 24'h0 : {1'b1, a_mag[22:0]});
    y_sig   = swap ? (a_zero ? 24'h0 : {1'b1, a_mag[22:0]})
                   : (b_zero ? 24'h0 : {1'b1, b_mag[22:0]});

    exp_diff = x_exp - y_exp;
    y_shift  = (exp_diff >= 8'd25) ? 24'h0 : (y_sig >> exp_diff);
  end

  // Significand add/subtract and leading-one detection for the subtract path.
  always_comb begin
    sum  = {1'b0, x_sig} + {1'b0, y_shift};
    diff = x_sig - y_shift;

    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!lz_found) begin
        if (diff[i]) lz_found = 1'b1;
        else         lz = lz + 5'd1;
      end
    end

    diff_norm = diff << lz;
    add_exp   = {1'b0, x_exp} + {8'h00, sum[24]};
    sub_exp   = $signed({2'b00, x_exp}) - $signed({5'b00000, lz});
  end

  // Result selection: specials, zero, overflow, underflow, then the normal case.
  always_comb begin
    result_d    = 32'h0000_0000;
    exception_d = 1'b0;
    if (any_special) begin
      result_d    = 32'h7FC0_0000;
      exception_d = 1'b1;
    end else if (x_sig == 24'h0) begin
      // Both operands flushed to zero.
      result_d = 32'h0000_0000;
    end else if (!eff_sub) begin
      if (add_exp == 9'd255) begin
        result_d    = {x_sign, 8'hFF, 23'h0};
        exception_d = 1'b1;
      end else if (sum[24]) begin
        result_d = {x_sign, add_exp[7:0], sum[23:1]};
      end else begin
        result_d = {x_sign, add_exp[7:0], sum[22:0]};
      end
    end else begin
      if (diff == 24'h0) begin
        // Exact cancellation always gives +0.
        result_d = 32'h0000_0000;
      end else if (sub_exp <= 10'sd0) begin
        result_d = {x_sign, 31'h0};
      end else begin
        result_d = {x_sign, sub_exp[7:0], diff_norm[22:0]};
      end
    end
  end

  // Output register; reset clears it immediately and drops any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= 32'h0000_0000;
      exception_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      exception_q <= exception_d;
    end
  end

  assign Result    = result_q;
  assign Exception = exception_q;

endmodule

// File: tb/tb_addition_subtraction.sv
// Self-checking bench for addition_subtraction: directed vector table, reset/latency sequences
// and randomized operations checked against a behavioural fp32 model.
module tb_addition_subtraction;

  logic        clk;
  logic        reset;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        AddBar_Sub;
  logic        Exception;
  logic [31:0] Result;

  int checks;
  int errors;

  addition_subtraction dut (
    .clk        (clk),
    .reset      (reset),
    .a_operand  (a_operand),
    .b_operand  (b_operand),
    .AddBar_Sub (AddBar_Sub),
    .Exception  (Exception),
    .Result     (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
    logic        e;
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got_r, input logic got_e,
                       input logic [31:0] exp_r, input logic exp_e);
    checks++;
    if (got_r !== exp_r || got_e !== exp_e) begin
      errors++;
      $display("FAIL %s: got Result=%h Exception=%b, expected Result=%h Exception=%b",
               name, got_r, got_e, exp_r, exp_e);
    end
  endtask

  // Behavioural model: values as integers, Y truncated by the alignment shift, then
  // renormalized by repeated doubling/halving.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic op,
                                    output logic [31:0] r, output logic e);
    int     ea, eb, ex, ey, d, ee;
    longint ma, mb, mx, my, va, vb, yv, acc;
    logic   sa, sb, sx;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sb = b[31] ^ op;
    r  = 32'h0;
    e  = 1'b0;
    if (ea == 255 || eb == 255) begin
      r = 32'h7FC0_0000;
      e = 1'b1;
      return;
    end
    ma = (ea == 0) ? 0 : (longint'(a[22:0]) + 64'd8388608);
    mb = (eb == 0) ? 0 : (longint'(b[22:0]) + 64'd8388608);
    va = (ea == 0) ? 0 : longint'(a[30:0]);
    vb = (eb == 0) ? 0 : longint'(b[30:0]);
    if (va == 0 && vb == 0) return;
    if (vb > va) begin
      sx = sb; mx = mb; ex = eb; my = ma; ey = ea;
    end else begin
      sx = sa; mx = ma; ex = ea; my = mb; ey = eb;
    end
    d  = ex - ey;
    yv = (d >= 25) ? 0 : (my >> d);
    acc = (sa == sb) ? (mx + yv) : (mx - yv);
    if (acc == 0) return;
    ee = ex;
    while (acc >= 64'd16777216) begin acc = acc >> 1; ee++; end
    while (acc < 64'd8388608)   begin acc = acc << 1; ee--; end
    if (ee >= 255) begin
      r = {sx, 8'hFF, 23'h0};
      e = 1'b1;
    end else if (ee <= 0) begin
      r = {sx, 31'h0};
    end else begin
      r = {sx, 8'(ee), 23'(acc)};
    end
  endfunction

  // Drive at the falling edge, sample just after the following rising edge.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic op);
    @(negedge clk);
    a_operand  = a;
    b_operand  = b;
    AddBar_Sub = op;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_operand(input int ea);
    return {1'($urandom), 8'(ea), 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] exp_r;
    logic        exp_e;
    logic [31:0] ra, rb;
    logic        rop;
    int          ea, eb;

    checks = 0;
    errors = 0;

    vecs[0]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, "one_plus_one"};
    vecs[1]  = '{32'h415E_D852, 32'h40DE_D852, 1'b0, 32'h41A7_223D, 1'b0, "decay_sum"};
    vecs[2]  = '{32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 1'b0, "three_minus_one"};
    vecs[3]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0, "cancel"};
    vecs[4]  = '{32'hC000_0000, 32'h3F80_0000, 1'b0, 32'hBF80_0000, 1'b0, "mixed_sign"};
    vecs[5]  = '{32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b1, "inf_in"};
    vecs[6]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, "overflow"};
    vecs[7]  = '{32'h0000_0000, 32'h4040_0000, 1'b1, 32'hC040_0000, 1'b0, "zero_minus_b"};
    vecs[8]  = '{32'h0001_2345, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0, "denorm_flush"};
    vecs[9]  = '{32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h8000_0000, 1'b0, "underflow"};
    vecs[10] = '{32'h4B80_0000, 32'h3F80_0000, 1'b0, 32'h4B80_0000, 1'b0, "shift_out"};
    vecs[11] = '{32'h4000_0000, 32'h3F80_0001, 1'b1, 32'h3F80_0000, 1'b0, "sub_truncate"};
    vecs[12] = '{32'h3F80_0000, 32'h7FC0_0001, 1'b1, 32'h7FC0_0000, 1'b1, "nan_in_b"};

    reset      = 1'b1;
    a_operand  = 32'h3F80_0000;
    b_operand  = 32'h3F80_0000;
    AddBar_Sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", Result, Exception, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table, applied back to back.
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].op);
      check(vecs[i].name, Result, Exception, vecs[i].r, vecs[i].e);
    end

    // Reset asserted between edges while Result is nonzero clears outputs at once.
    apply(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    check("pre_reset", Result, Exception, 32'h4000_0000, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", Result, Exception, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", Result, Exception, 32'h0, 1'b0);
    @(negedge clk);
    reset      = 1'b0;
    a_operand  = 32'h4040_0000;
    b_operand  = 32'h3F80_0000;
    AddBar_Sub = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_release", Result, Exception, 32'h4000_0000, 1'b0);

    // One-cycle latency: just before the next edge the previous result is still held.
    @(negedge clk);
    a_operand  = 32'h3F80_0000;
    b_operand  = 32'h3F80_0000;
    AddBar_Sub = 1'b0;
    #4;
    check("held_until_edge", Result, Exception, 32'h4000_0000, 1'b0);
    @(posedge clk);
    #1;
    check("next_edge_result", Result, Exception, 32'h4000_0000, 1'b0);

    // Randomized back-to-back operations against the model.
    for (int n = 0; n < 400; n++) begin
      ea = int'($urandom_range(1, 254));
      eb = ea + int'($urandom_range(0, 60)) - 30;
      if (eb < 1)   eb = 1;
      if (eb > 254) eb = 254;
      case ($urandom_range(0, 15))
        0:       eb = 0;
        1:       eb = 255;
        2:       ea = 0;
        default: ;
      endcase
      ra  = rand_operand(ea);
      rb  = rand_operand(eb);
      rop = 1'($urandom);
      if ($urandom_range(0, 9) == 0) rb = ra;
      if ($urandom_range(0, 9) == 0) rb = {rb[31:23], ra[22:0]};
      ref_model(ra, rb, rop, exp_r, exp_e);
      apply(ra, rb, rop);
      check("random_op", Result, Exception, exp_r, exp_e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
